// File: rtl/cmp_nic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmp_nic_pkg                                            |
// | Description : Shared constants for the CMP network interface:        |
// |               register address map, VC bit index, default width.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cmp_nic_pkg;

  localparam int unsigned DATA_W_DEFAULT = 64;

  // Register address map seen by the processor
  localparam logic [1:0] ADDR_ICB = 2'b00;
  localparam logic [1:0] ADDR_ISR = 2'b01;
  localparam logic [1:0] ADDR_OCB = 2'b10;
  localparam logic [1:0] ADDR_OSR = 2'b11;

  // Virtual-channel bit of an outgoing packet (bit 0 is the MSB)
  localparam int unsigned VC_BIT = 0;

endpackage : cmp_nic_pkg
`default_nettype wire

// File: rtl/cmp_nic_chbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmp_nic_chbuf                                          |
// | Description : One-entry channel buffer with a full flag. A load      |
// |               strobe captures data and sets full; a clear strobe     |
// |               drops the full flag. Load wins if both are asserted.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmp_nic_chbuf
  import cmp_nic_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [0:DATA_W-1] din,
  output logic [0:DATA_W-1] data,
  output logic              full
);

  logic [0:DATA_W-1] r_data;
  logic              r_full;

  // Entry storage and occupancy flag; reset overrides any same-edge strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (load) begin
      r_data <= din;
      r_full <= 1'b1;
    end else if (clear) begin
      r_full <= 1'b0;
    end
  end

  assign data = r_data;
  assign full = r_full;

endmodule : cmp_nic_chbuf
`default_nettype wire

// File: rtl/cmp_nic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmp_nic                                                |
// | Description : Memory-mapped network interface between a processor   |
// |               pipeline and a router. One-entry input and output      |
// |               channel buffers with status registers.                 |
// |               Optional: NIC_POLARITY_CHECK_EN gates sends on the     |
// |               packet VC bit matching the router polarity.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmp_nic
  import cmp_nic_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic              w_rd;
  logic              w_wr;
  logic              w_icb_load;
  logic              w_icb_clear;
  logic              w_ocb_load;
  logic              w_pol_ok;
  logic              w_icb_full;
  logic              w_ocb_full;
  logic [0:DATA_W-1] w_icb;
  logic [0:DATA_W-1] w_ocb;

  assign w_rd = nicEn & ~nicWrEn;
  assign w_wr = nicEn & nicWrEn;

  // Router side: accept whenever the input buffer is empty
  assign net_ri     = ~w_icb_full;
  assign w_icb_load = net_si & net_ri;
  // Reading the input buffer consumes it; clearing an empty flag is a no-op
  assign w_icb_clear = w_rd & (addr == ADDR_ICB);

  // A store to a full output buffer is dropped; a same-edge send still
  // sees the pre-edge full flag, so that store is dropped as well
  assign w_ocb_load = w_wr & (addr == ADDR_OCB) & ~w_ocb_full;

`ifdef NIC_POLARITY_CHECK_EN
  assign w_pol_ok = (w_ocb[VC_BIT] == net_polarity);
`else
  assign w_pol_ok = 1'b1;
  logic w_unused_pol;
  assign w_unused_pol = net_polarity;
`endif

  assign net_so = w_ocb_full & net_ro & w_pol_ok;
  assign net_do = w_ocb;

  cmp_nic_chbuf #(.DATA_W(DATA_W)) u_icb (
    .clk   (clk),
    .reset (reset),
    .load  (w_icb_load),
    .clear (w_icb_clear),
    .din   (net_di),
    .data  (w_icb),
    .full  (w_icb_full)
  );

  cmp_nic_chbuf #(.DATA_W(DATA_W)) u_ocb (
    .clk   (clk),
    .reset (reset),
    .load  (w_ocb_load),
    .clear (net_so),
    .din   (d_in),
    .data  (w_ocb),
    .full  (w_ocb_full)
  );

  // Processor load path: register select by address, zero when not loading
  always_comb begin
    d_out = '0;
    if (w_rd) begin
      case (addr)
        ADDR_ICB: d_out = w_icb;
        ADDR_ISR: d_out = {{(DATA_W-1){1'b0}}, w_icb_full};
        ADDR_OCB: d_out = w_ocb;
        ADDR_OSR: d_out = {{(DATA_W-1){1'b0}}, w_ocb_full};
        default:  d_out = '0;
      endcase
    end
  end

endmodule : cmp_nic
`default_nettype wire
